// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle: CPU request/response side and memory side.
// The unit is the slave; the requester/memory model is the master.
interface load_store_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  in_valid;
  logic [5:0]            opcode;
  logic [ADDR_W-1:0]     addr;
  logic [1:0]            mem_size;
  logic                  mem_signed;
  logic [DATA_W-1:0]     st_data;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     ld_data;
  logic [1:0]            ld_class;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_ack;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  in_valid, opcode, addr, mem_size, mem_signed, st_data,
    input  mem_ack, mem_rdata,
    output ready, done, err, ld_data, ld_class,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output in_valid, opcode, addr, mem_size, mem_signed, st_data,
    output mem_ack, mem_rdata,
    input  ready, done, err, ld_data, ld_class,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: decodes a request, aligns it onto the memory lanes,
// waits for the memory ack with a timeout and returns the extended load.
module load_store_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cls_q;
  logic [DATA_W-1:0]   ld_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   wd_q;
  logic [1:0]          size_q;
  logic                sgn_q;
  logic                we_q;
  logic [OW-1:0]       off_q;
  logic [CW-1:0]       cnt_q;

  logic [1:0]          cls;
  logic                bad;
  logic [OW-1:0]       off;
  logic [NB-1:0]       be_mask;
  logic [DATA_W-1:0]   sh, tmp, res;
  logic signed [DATA_W-1:0] stmp;
  int                  amt;

  assign off = bus.addr[OW-1:0];

  // Opcode class decode
  always_comb begin
    cls = 2'b00;
    unique case (1'b1)
      (bus.opcode == 6'b000000): cls = 2'b01;
      (bus.opcode == 6'b111011): cls = 2'b11;
      (bus.opcode == 6'b111100): cls = 2'b10;
      default: cls = 2'b00;
    endcase
  end

  // Alignment / legality check and byte-enable mask by size
  always_comb begin
    bad     = 1'b0;
    be_mask = '0;
    unique case (bus.mem_size)
      2'b00: begin
        be_mask = NB'(1);
      end
      2'b01: begin
        bad     = bus.addr[0];
        be_mask = NB'(3);
      end
      2'b10: begin
        bad     = |bus.addr[1:0];
        be_mask = NB'(15);
      end
      default: begin
        bad     = (DATA_W == 32) || (|bus.addr[2:0]);
        be_mask = '1;
      end
    endcase
  end

  // Load result: shift lane down, truncate to size, zero/sign extend
  always_comb begin
    amt = 0;
    sh  = bus.mem_rdata >> {off_q, 3'b000};
    unique case (size_q)
      2'b00:   amt = DATA_W - 8;
      2'b01:   amt = DATA_W - 16;
      2'b10:   amt = DATA_W - 32;
      default: amt = 0;
    endcase
    tmp  = sh << amt;
    stmp = tmp;
    if (sgn_q) res = stmp >>> amt;
    else       res = tmp >> amt;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (!cls[1])  state_d = DONE;
          else if (bad) state_d = ERR;
          else          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_ack)
          state_d = DONE;
        else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT))
          state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and load capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_q  <= '0;
      ld_q   <= '0;
      addr_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
      size_q <= '0;
      sgn_q  <= 1'b0;
      we_q   <= 1'b0;
      off_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (state_q == IDLE && bus.in_valid) begin
        cls_q <= cls;
        ld_q  <= '0;
        if (cls[1] && !bad) begin
          addr_q <= {bus.addr[ADDR_W-1:OW], OW'(0)};
          be_q   <= be_mask << off;
          wd_q   <= bus.st_data << {off, 3'b000};
          size_q <= bus.mem_size;
          sgn_q  <= bus.mem_signed;
          we_q   <= ~cls[0];
          off_q  <= off;
          cnt_q  <= CW'(1);
        end
      end
      if (state_q == ACCESS) begin
        if (bus.mem_ack) begin
          if (!we_q) ld_q <= res;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = (state_q == DONE) || (state_q == ERR);
  assign bus.err       = (state_q == ERR);
  assign bus.mem_req   = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wd_q;
  assign bus.ld_data   = ld_q;
  assign bus.ld_class  = cls_q;
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the data bus width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning the maximum ACCESS cycles before an error; 0 disables the timeout.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have these request ports:
- in_valid in 1: request strobe.
- opcode in 6: instruction opcode.
- addr in ADDR_W: byte address.
- mem_size in 2: 00 byte, 01 half, 10 word, 11 dword.
- mem_signed in 1: sign-extend loads.
- st_data in DATA_W: store data, right-aligned.
REQ-006 SHALL have these response ports:
- ready out 1: able to accept a request.
- done out 1: one-cycle completion pulse.
- err out 1: one-cycle error pulse, coincident with done.
- ld_data out DATA_W: load result, valid while done=1 for a load.
- ld_class out 2: class of the last accepted opcode.
REQ-007 SHALL have these memory ports:
- mem_req out 1: memory request.
- mem_we out 1: write enable.
- mem_addr out ADDR_W: lane-aligned address.
- mem_be out DATA_W/8: byte enables.
- mem_wdata out DATA_W: lane-positioned store data.
- mem_ack in 1: memory completion.
- mem_rdata in DATA_W: read data, valid with mem_ack.

Function
REQ-008 SHALL decode opcode: 000000 -> class 01 (R-type); 111011 -> 11 (load); 111100 -> 10 (store); any other -> 00.
REQ-009 SHALL register ld_class on every accepted request and hold it until the next accept.
REQ-010 SHALL implement the FSM states IDLE, ACCESS, DONE and ERR; ready=1 only in IDLE.
REQ-011 SHALL accept a request only when in_valid=1 in IDLE; in_valid in any other state is ignored, not queued.
REQ-012 SHALL route an accepted non-memory class (01/00) IDLE -> DONE, with no memory activity.
REQ-013 SHALL check alignment for loads and stores, with OFF the low log2(DATA_W/8) address bits:
- Half is misaligned if addr[0]=1; word if addr[1:0]!=0; dword if addr[2:0]!=0.
- mem_size=11 with DATA_W=32 is illegal.
- A misaligned or illegal request goes IDLE -> ERR; otherwise it latches addr, size, signed and data, and goes IDLE -> ACCESS.
REQ-014 SHALL hold mem_req=1 in ACCESS only; mem_we=1 for stores, 0 for loads.
REQ-015 SHALL drive mem_addr = addr with OFF cleared.
REQ-016 SHALL drive mem_be with size-many ones shifted left by OFF.
REQ-017 SHALL drive mem_wdata = st_data shifted left by 8*OFF.
REQ-018 SHALL go ACCESS -> DONE on mem_ack=1, capturing the load result that cycle:
- result = mem_rdata >> 8*OFF, truncated to size, then zero- or sign-extended (mem_signed) to DATA_W.
REQ-019 SHALL, for a store, set ld_data to 0 in DONE.
REQ-020 SHALL count ACCESS cycles, starting from 1 on entry; when the count reaches TIMEOUT without mem_ack, the FSM goes ACCESS -> ERR.
- If mem_ack arrives in the same cycle the count reaches TIMEOUT, mem_ack wins.
REQ-021 SHALL pulse done=1 for one cycle in DONE, then return to IDLE.
REQ-022 SHALL pulse done=1 and err=1 for one cycle in ERR, with ld_data=0, then return to IDLE.
REQ-023 SHALL ignore mem_ack outside ACCESS.
REQ-024 SHALL have a latency, from the accept edge (cycle N) to done, of:
- Zero-wait memory (mem_ack in the first ACCESS cycle): done in cycle N+2.
- Non-memory op: done in cycle N+1.
- Each memory wait cycle adds 1.
REQ-025 SHALL drive all outputs from registers or from the state decode only; there is no combinational path from the inputs to the outputs.

Reset
REQ-026 SHALL, when rst=1 at a clock edge, put the FSM in IDLE and set ready=1.
- done, err, mem_req and mem_we go to 0; ld_data, ld_class, mem_addr, mem_be, mem_wdata and the counter go to 0.
REQ-027 SHALL abort a transaction on rst in ACCESS: mem_req falls at that edge, no done/err is produced, and a later mem_ack is ignored.

Verification
REQ-028 SHALL cover a signed byte load: DATA_W=32, opcode 111011, addr 0x1003, size 00, signed 1; mem_rdata 0x80FFFFFF acked in the first cycle.
- Required: mem_addr 0x1000, mem_be 1000, done at N+2, ld_data 0xFFFFFF80, ld_class 11.
REQ-029 SHALL cover a halfword store: opcode 111100, addr 0x2002, size 01, st_data 0x0000BEEF, with 3 wait cycles.
- Required: mem_we=1, mem_be 1100, mem_wdata 0xBEEF0000, done at N+5, err=0.
REQ-030 SHALL cover misalignment: a word load at addr 0x0006.
- Required: no mem_req, done=err=1 at N+1, ld_data 0; a dword request with DATA_W=32 behaves identically.
REQ-031 SHALL cover the timeout: TIMEOUT=4, load, mem_ack never asserted.
- Required: mem_req high 4 cycles, err=done=1 next; a repeat with mem_ack on the 4th cycle gives done=1, err=0.
REQ-032 SHALL cover an R-type op and a request while busy: opcode 000000 in IDLE, then in_valid pulsed during a load's ACCESS.
- Required: R-type gives done at N+1 with ld_class 01; the busy-time request is dropped, with no second done.
REQ-033 SHALL cover reset mid-ACCESS: assert rst during ACCESS, then mem_ack one cycle later.
- Required: mem_req 0, ready 1, done/err never pulse, all outputs at their reset values.
